// File: rtl/multicycle_alu.sv
// Handshaked ALU: single-cycle logic/arith/shift ops, optional iterative MUL/DIV/REM.
// Define ALU_MULDIV_EN to build ops 10-12; otherwise they complete as illegal ops.
module multicycle_alu #(
  parameter int WIDTH = 19,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [4:0]       flags
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_INC = 4'd2;
  localparam logic [3:0] OP_DEC = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4;
  localparam logic [3:0] OP_OR  = 4'd5;
  localparam logic [3:0] OP_XOR = 4'd6;
  localparam logic [3:0] OP_NOT = 4'd7;
  localparam logic [3:0] OP_SHL = 4'd8;
  localparam logic [3:0] OP_SHR = 4'd9;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  // Returns {overflow, carry/borrow, sum}; overflow uses the operand sign bits.
  function automatic logic [WIDTH+1:0] add_sub(input logic signed [WIDTH-1:0] x,
                                               input logic signed [WIDTH-1:0] y,
                                               input logic                    sub);
    logic [WIDTH:0] r;
    logic           v;
    r = sub ? ({1'b0, x} - {1'b0, y}) : ({1'b0, x} + {1'b0, y});
    v = (x[WIDTH-1] ^ r[WIDTH-1]) & (x[WIDTH-1] ^ y[WIDTH-1] ^ ~sub);
    return {v, r};
  endfunction

  logic [1:0]       state;
  logic             accept;
  logic [WIDTH-1:0] as_y;
  logic             as_sub;
  logic [WIDTH+1:0] as_out;
  logic [SHW-1:0]   shamt;
  logic             sh_big;
  logic [WIDTH-1:0] sc_res;
  logic             sc_ill;
  logic             sc_v;
  logic             sc_c;

  assign in_ready  = (state == S_IDLE) && !reset;
  assign out_valid = (state == S_DONE);
  assign accept    = in_valid && in_ready;

  assign shamt  = b[SHW-1:0];
  assign sh_big = 32'(shamt) >= 32'(WIDTH);
  assign as_y   = ((op == OP_INC) || (op == OP_DEC)) ? ONE : b;
  assign as_sub = (op == OP_SUB) || (op == OP_DEC);
  assign as_out = add_sub(a, as_y, as_sub);

`ifdef ALU_MULDIV_EN
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [3:0] OP_MUL = 4'd10;
  localparam logic [3:0] OP_DIV = 4'd11;
  localparam logic [3:0] OP_REM = 4'd12;
  localparam int         CW     = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic                 is_iter;
  logic [CW-1:0]        iter_cnt;
  logic [3:0]           it_op;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0]   acc_nxt;
  logic [WIDTH-1:0]     mplier;
  logic [WIDTH-1:0]     divisor;
  logic [WIDTH-1:0]     rem;
  logic [WIDTH-1:0]     quo;
  logic [WIDTH-1:0]     rem_nxt;
  logic [WIDTH-1:0]     quo_nxt;
  logic [WIDTH-1:0]     diff;
  logic [WIDTH:0]       shifted;
  logic                 ge;
  logic [WIDTH-1:0]     it_res;
  logic [4:0]           it_flags;

  // One partial product and one restoring-division step per BUSY cycle; the
  // final step's next-values are written straight into result on the last edge.
  always_comb begin
    acc_nxt  = mplier[0] ? (acc + mcand) : acc;
    shifted  = {rem, quo[WIDTH-1]};
    ge       = shifted >= {1'b0, divisor};
    diff     = shifted[WIDTH-1:0] - divisor;
    rem_nxt  = ge ? diff : shifted[WIDTH-1:0];
    quo_nxt  = {quo[WIDTH-2:0], ge};
    it_res   = quo_nxt;
    it_flags = '0;
    case (it_op)
      OP_MUL: begin
        it_res      = acc_nxt[WIDTH-1:0];
        it_flags[2] = |acc_nxt[2*WIDTH-1:WIDTH];
      end
      OP_REM: begin
        it_res      = rem_nxt;
        it_flags[3] = (divisor == '0);
      end
      default: begin
        it_res      = quo_nxt;
        it_flags[3] = (divisor == '0);
      end
    endcase
    it_flags[0] = (it_res == '0);
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      acc     <= '0;
      mcand   <= {{WIDTH{1'b0}}, a};
      mplier  <= b;
      rem     <= '0;
      quo     <= a;
      divisor <= b;
      it_op   <= op;
    end else if (state == S_BUSY) begin
      acc    <= acc_nxt;
      mcand  <= {mcand[2*WIDTH-2:0], 1'b0};
      mplier <= {1'b0, mplier[WIDTH-1:1]};
      rem    <= rem_nxt;
      quo    <= quo_nxt;
    end
  end
`endif

  always_comb begin
    sc_res = '0;
    sc_ill = 1'b0;
    sc_v   = 1'b0;
    sc_c   = 1'b0;
`ifdef ALU_MULDIV_EN
    is_iter = 1'b0;
`endif
    case (op)
      OP_ADD, OP_SUB, OP_INC, OP_DEC: {sc_v, sc_c, sc_res} = as_out;
      OP_AND: sc_res = a & b;
      OP_OR:  sc_res = a | b;
      OP_XOR: sc_res = a ^ b;
      OP_NOT: sc_res = ~a;
      OP_SHL: sc_res = sh_big ? '0 : (a << shamt);
      OP_SHR: sc_res = sh_big ? '0 : (a >> shamt);
`ifdef ALU_MULDIV_EN
      OP_MUL, OP_DIV, OP_REM: is_iter = 1'b1;
`endif
      default: sc_ill = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      result <= '0;
      flags  <= '0;
`ifdef ALU_MULDIV_EN
      iter_cnt <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
`ifdef ALU_MULDIV_EN
            iter_cnt <= '0;
            if (is_iter) state <= S_BUSY;
            else
`endif
            begin
              state  <= S_DONE;
              result <= sc_res;
              flags  <= {sc_ill, 1'b0, sc_v, sc_c, (sc_res == '0)};
            end
          end
        end
`ifdef ALU_MULDIV_EN
        S_BUSY: begin
          iter_cnt <= iter_cnt + 1'b1;
          if (iter_cnt == LAST) begin
            state  <= S_DONE;
            result <= it_res;
            flags  <= it_flags;
          end
        end
`endif
        S_DONE: if (out_ready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_alu.sv
// Directed bench for multicycle_alu at WIDTH=19; MUL/DIV/REM cases follow ALU_MULDIV_EN.
module tb_multicycle_alu;
  localparam int W = 19;

  typedef struct packed {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic [4:0]   fl;
  } vec_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic [4:0]   flags;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  multicycle_alu dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags)
  );

  // Called 1 time unit after an edge with the DUT idle; returns just after the accept edge.
  task automatic send(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    op = o; a = x; b = y; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; a = ~x; b = ~y;
  endtask

  task automatic take();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = '0; a = '0; b = '0;
    @(posedge clk); #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready_hi got=%b want=0", in_ready); end
    @(posedge clk); #1;
    reset = 1'b0; #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b want=0", out_valid); end
    total++; if (result !== '0) begin bad++; $display("FAIL rst_result got=%h want=0", result); end
    total++; if (flags !== 5'b0) begin bad++; $display("FAIL rst_flags got=%b want=00000", flags); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b want=1", in_ready); end
  endtask

  task automatic test_single_cycle();
    vec_t v [19] = '{
      '{4'd0,  19'h3FFFF, 19'h00001, 19'h40000, 5'b00100},
      '{4'd1,  19'h00005, 19'h00007, 19'h7FFFE, 5'b00010},
      '{4'd1,  19'h12345, 19'h12345, 19'h00000, 5'b00001},
      '{4'd0,  19'h7FFFF, 19'h00001, 19'h00000, 5'b00011},
      '{4'd2,  19'h7FFFF, 19'h00055, 19'h00000, 5'b00011},
      '{4'd2,  19'h3FFFF, 19'h00000, 19'h40000, 5'b00100},
      '{4'd3,  19'h00000, 19'h00000, 19'h7FFFF, 5'b00010},
      '{4'd3,  19'h40000, 19'h00009, 19'h3FFFF, 5'b00100},
      '{4'd4,  19'h0F0F0, 19'h0FF00, 19'h0F000, 5'b00000},
      '{4'd5,  19'h0F0F0, 19'h0FF00, 19'h0FFF0, 5'b00000},
      '{4'd6,  19'h0F0F0, 19'h0FF00, 19'h00FF0, 5'b00000},
      '{4'd7,  19'h0F0F0, 19'h00000, 19'h70F0F, 5'b00000},
      '{4'd4,  19'h55555, 19'h2AAAA, 19'h00000, 5'b00001},
      '{4'd8,  19'h00001, 19'd18,    19'h40000, 5'b00000},
      '{4'd8,  19'h00001, 19'd19,    19'h00000, 5'b00001},
      '{4'd8,  19'h7FFFF, 19'h00020, 19'h7FFFF, 5'b00000},
      '{4'd9,  19'h40000, 19'd18,    19'h00001, 5'b00000},
      '{4'd9,  19'h40000, 19'h0001F, 19'h00000, 5'b00001},
      '{4'd9,  19'h7FFFF, 19'd4,     19'h07FFF, 5'b00000}
    };
    for (int i = 0; i < 19; i++) begin
      send(v[i].op, v[i].a, v[i].b);
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL sc_valid[%0d] got=%b want=1", i, out_valid); end
      total++; if (result !== v[i].res) begin bad++; $display("FAIL sc_result[%0d] op=%0d got=%h want=%h", i, v[i].op, result, v[i].res); end
      total++; if (flags !== v[i].fl) begin bad++; $display("FAIL sc_flags[%0d] op=%0d got=%b want=%b", i, v[i].op, flags, v[i].fl); end
      take();
      total++; if ({out_valid, in_ready} !== 2'b01) begin bad++; $display("FAIL sc_release[%0d] got vld/rdy=%b want=01", i, {out_valid, in_ready}); end
    end
  endtask

  task automatic test_illegal();
    for (int o = 10; o < 16; o++) begin
`ifdef ALU_MULDIV_EN
      if (o < 13) continue;
`endif
      send(4'(o), 19'h12345, 19'h00007);
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL ill_valid op=%0d got=%b want=1", o, out_valid); end
      total++; if (result !== '0) begin bad++; $display("FAIL ill_result op=%0d got=%h want=0", o, result); end
      total++; if (flags !== 5'b10001) begin bad++; $display("FAIL ill_flags op=%0d got=%b want=10001", o, flags); end
      take();
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    send(4'd0, 19'd1, 19'd2);
    total++; if ({out_valid, result} !== {1'b1, 19'd3}) begin bad++; $display("FAIL b2b_first got vld=%b res=%h want vld=1 res=3", out_valid, result); end
    @(posedge clk); #1;
    total++; if ({out_valid, in_ready} !== 2'b01) begin bad++; $display("FAIL b2b_gap got vld/rdy=%b want=01", {out_valid, in_ready}); end
    send(4'd1, 19'd9, 19'd4);
    total++; if ({out_valid, result} !== {1'b1, 19'd5}) begin bad++; $display("FAIL b2b_second got vld=%b res=%h want vld=1 res=5", out_valid, result); end
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    logic hold_bad;
    hold_bad = 1'b0;
    send(4'd6, 19'h0F0F0, 19'h0FF00);
    for (int i = 0; i < 5; i++) begin
      op = 4'd0; a = 19'd1; b = 19'd1; in_valid = 1'b1;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== 19'h00FF0 || flags !== 5'b0)
        hold_bad = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    total++; if (hold_bad !== 1'b0) begin bad++; $display("FAIL bp_hold got unstable output, last res=%h flg=%b want res=00ff0 flg=00000", result, flags); end
    total++; if (result !== 19'h00FF0) begin bad++; $display("FAIL bp_result got=%h want=00ff0", result); end
    take();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_release got=%b want=0", out_valid); end
    @(posedge clk); #1;
    total++; if ({out_valid, in_ready} !== 2'b01) begin bad++; $display("FAIL bp_no_queue got vld/rdy=%b want=01", {out_valid, in_ready}); end
  endtask

`ifdef ALU_MULDIV_EN
  task automatic test_muldiv();
    vec_t v [7] = '{
      '{4'd10, 19'd300,    19'd400,   19'd120000, 5'b00000},
      '{4'd10, 19'h00400,  19'h00400, 19'h00000,  5'b00101},
      '{4'd10, 19'h7FFFF,  19'd1,     19'h7FFFF,  5'b00000},
      '{4'd11, 19'd100000, 19'd7,     19'd14285,  5'b00000},
      '{4'd12, 19'd100000, 19'd7,     19'd5,      5'b00000},
      '{4'd11, 19'd9,      19'd0,     19'h7FFFF,  5'b01000},
      '{4'd12, 19'd9,      19'd0,     19'd9,      5'b01000}
    };
    int   lat;
    logic busy_bad;
    for (int i = 0; i < 7; i++) begin
      send(v[i].op, v[i].a, v[i].b);
      lat = 0;
      busy_bad = 1'b0;
      while (out_valid !== 1'b1 && lat < 40) begin
        if (in_ready !== 1'b0) busy_bad = 1'b1;
        op = 4'd0; a = 19'd1; b = 19'd1; in_valid = 1'b1;
        @(posedge clk); #1;
        lat++;
      end
      in_valid = 1'b0;
      total++; if (lat !== 19) begin bad++; $display("FAIL md_latency[%0d] got=%0d want=19", i, lat); end
      total++; if (busy_bad !== 1'b0) begin bad++; $display("FAIL md_busy_ready[%0d] got in_ready=1 in BUSY want=0", i); end
      total++; if (result !== v[i].res) begin bad++; $display("FAIL md_result[%0d] op=%0d got=%h want=%h", i, v[i].op, result, v[i].res); end
      total++; if (flags !== v[i].fl) begin bad++; $display("FAIL md_flags[%0d] op=%0d got=%b want=%b", i, v[i].op, flags, v[i].fl); end
      take();
    end
  endtask
`endif

  task automatic test_abort();
    logic seen;
`ifdef ALU_MULDIV_EN
    send(4'd10, 19'd300, 19'd400);
    repeat (5) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    total++; if ({out_valid, result, flags} !== '0) begin bad++; $display("FAIL abort_busy got vld=%b res=%h flg=%b want all 0", out_valid, result, flags); end
    reset = 1'b0;
    seen = 1'b0;
    repeat (30) begin
      if (out_valid !== 1'b0) seen = 1'b1;
      @(posedge clk); #1;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL abort_busy_quiet got out_valid=1 want=0"); end
`endif
    send(4'd6, 19'h0F0F0, 19'h0FF00);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    total++; if ({out_valid, result, flags} !== '0) begin bad++; $display("FAIL abort_done got vld=%b res=%h flg=%b want all 0", out_valid, result, flags); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL abort_rdy_in_reset got=%b want=0", in_ready); end
    reset = 1'b0;
    seen = 1'b0;
    repeat (5) begin
      if (out_valid !== 1'b0) seen = 1'b1;
      @(posedge clk); #1;
    end
    total++; if ({seen, in_ready} !== 2'b01) begin bad++; $display("FAIL abort_done_quiet got seen/rdy=%b want=01", {seen, in_ready}); end
    send(4'd0, 19'd2, 19'd3);
    total++; if ({out_valid, result, flags} !== {1'b1, 19'd5, 5'b0}) begin bad++; $display("FAIL abort_recover got vld=%b res=%h flg=%b want vld=1 res=5 flg=0", out_valid, result, flags); end
    take();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_cycle();
    test_illegal();
    test_back_to_back();
    test_backpressure();
`ifdef ALU_MULDIV_EN
    test_muldiv();
`endif
    test_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
